serial_adder: RTL
=================

// Module: serial_adder
//
// PURPOSE
//   Parametrised bit-serial adder: the sequential successor to half_adder.
//   - Adds two WIDTH-bit operands plus a carry-in, one bit per clock.
//   - Uses a single full-adder cell and a carry flip-flop.
//   - start/busy/done handshake; area-lean alternative to a ripple adder.
//   - Standalone arithmetic unit, driven by a controller or a testbench.
//
// PARAMETERS
//   WIDTH  8  operand/result width in bits; legal range >= 1
//   CNT_W  $clog2(WIDTH+1)  localparam, width of the bit counter
//
// PORTS
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous reset, active low
//   start  in   1      request; sampled only when not busy
//   c_in   in   1      carry-in, captured with start
//   a      in   WIDTH  operand A, captured with start
//   b      in   WIDTH  operand B, captured with start
//   busy   out  1      high while bits are being processed
//   done   out  1      one-cycle pulse: suma/c_out just updated
//   suma   out  WIDTH  sum; holds value until next completion
//   c_out  out  1      carry-out of MSB; holds like suma
//   ovf    out  1      signed overflow (only with SERIAL_ADDER_OVF_EN)
//
// BEHAVIOUR
//   - Reset (rst_n=0, async): state=IDLE; busy=0, done=0, suma=0, c_out=0, ovf=0.
//     Internal shift registers, counter and carry FF are also cleared.
//   - FSM states: IDLE -> SHIFT -> DONE -> IDLE.
//   - IDLE or DONE, start=1 at edge k:
//     - latch a, b into shift regs; carry FF <= c_in; cnt <= 0; -> SHIFT.
//     - Back-to-back starts from DONE are accepted.
//   - SHIFT, edges k+1 .. k+WIDTH:
//     - bit i = cnt, LSB first: s_i = a_i ^ b_i ^ c; c <= majority(a_i, b_i, c).
//     - s_i is shifted into the result register from the MSB side.
//     - Operand regs shift right; cnt++.
//   - Completion, edge k+WIDTH (cnt == WIDTH-1):
//     - suma <= full sum; c_out <= final carry; done <= 1; -> DONE.
//   - DONE lasts exactly one cycle; done clears on the next edge.
//   - Latency and throughput:
//     - done is high in the cycle after edge k+WIDTH.
//     - Throughput is one add per WIDTH+1 cycles.
//   - busy=1 exactly in SHIFT (WIDTH cycles). start, a, b, c_in are ignored while busy.
//   - Result: {c_out, suma} == a + b + c_in, computed modulo 2^(WIDTH+1) (unsigned).
//   - suma and c_out change only at completion. They hold stale values during SHIFT.
//   - WIDTH=1 degenerates to a registered full adder with 2-cycle latency.
//   - rst_n asserted mid-SHIFT: operation is aborted and all outputs return to reset values.
//     No done pulse is issued for the aborted add.
//
// CONFIGURATION
//   SERIAL_ADDER_OVF_EN defined:
//     - ovf port exists.
//     - At completion, ovf <= carry into MSB XOR carry out of MSB (two's-complement overflow).
//     - ovf updates and holds like suma; reset value 0.
//   SERIAL_ADDER_OVF_EN undefined:
//     - ovf port and its logic are absent.
//     - All other behaviour is identical.
//
// TESTING  (WIDTH=8 unless noted)
//   - reset then 0x00+0x00, c_in=0 -> done once after 9 edges; suma=0x00, c_out=0; busy high 8 cycles
//   - 0xFF+0x01, c_in=0 -> suma=0x00, c_out=1; 0x35+0x4A, c_in=1 -> suma=0x80, c_out=0 (ovf=1 if _EN)
//   - 0x7F+0x01 -> suma=0x80, ovf=1; 0x80+0x80 -> suma=0x00, c_out=1, ovf=1 (OVF_EN build)
//   - start pulsed with new operands during busy -> ignored; result is the first add only
//   - start held high from DONE -> second add accepted immediately; done pulses exactly 9 cycles apart
//   - rst_n low at 4th SHIFT cycle -> busy=0, suma=0, no done pulse; next add runs correctly
//   - WIDTH=1: 1+1, c_in=1 -> suma=1, c_out=1, done 2 edges after start

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first, start/busy/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             c_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] suma,
  output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   suma_q, suma_d;
  logic               carry_q, carry_d;
  logic               c_out_q, c_out_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic               s_bit, c_next, last_bit;
  logic [WIDTH:0]     res_shift;

  // Single full-adder cell; the new sum bit enters the result from the MSB side.
  always_comb begin
    s_bit     = a_q[0] ^ b_q[0] ^ carry_q;
    c_next    = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    res_shift = {s_bit, res_q};
    last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      suma_q  <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      suma_q  <= suma_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = start ? SHIFT : IDLE;
      SHIFT:      state_d = last_bit ? DONE : SHIFT;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    suma_d  = suma_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = c_next;
        cnt_d   = cnt_q + CNT_W'(1);
        res_d   = res_shift[WIDTH:1];
        if (last_bit) begin
          suma_d  = res_shift[WIDTH:1];
          c_out_d = c_next;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q here is the carry into the MSB cell
          ovf_d   = carry_q ^ c_next;
`endif
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy  = (state_q == SHIFT);
    done  = (state_q == DONE);
    suma  = suma_q;
    c_out = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf   = ovf_q;
`endif
  end

endmodule
